// File: rtl/vm_pkg.sv
// vm_pkg: shared types, default parameters and the seven-segment decode
// for the vending_machine block.
package vm_pkg;

    // One-hot controller states; the encoding is driven straight onto status.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_CREDIT = 4'b0010,
        ST_VEND   = 4'b0100,
        ST_REFUND = 4'b1000
    } state_e;

    // The single action chosen from the edge events of one cycle.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_COIN,
        ACT_REJECT,
        ACT_BUY1,
        ACT_BUY2,
        ACT_REFUND
    } action_e;

    localparam int unsigned DEF_PRICE_G1     = 3;
    localparam int unsigned DEF_PRICE_G2     = 10;
    localparam int unsigned DEF_MAX_BAL      = 99;
    localparam int unsigned DEF_PULSE_CYCLES = 4;
    localparam int unsigned DEF_SCAN_DIV     = 16;
    localparam int unsigned BAL_W            = 7;

    // BCD digit to active-low segments {dp,g,f,e,d,c,b,a}; dp always off.
    function automatic logic [7:0] seg7_decode(input logic [3:0] val);
        case (val)
            4'd0:    seg7_decode = 8'hC0;
            4'd1:    seg7_decode = 8'hF9;
            4'd2:    seg7_decode = 8'hA4;
            4'd3:    seg7_decode = 8'hB0;
            4'd4:    seg7_decode = 8'h99;
            4'd5:    seg7_decode = 8'h92;
            4'd6:    seg7_decode = 8'h82;
            4'd7:    seg7_decode = 8'hF8;
            4'd8:    seg7_decode = 8'h80;
            4'd9:    seg7_decode = 8'h90;
            default: seg7_decode = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/vending_machine_if.sv
// vending_machine_if: coin/button inputs plus indicator and display outputs.
// The master side is the panel (or bench); the slave side is the controller.
interface vending_machine_if;
    logic       one_yuan;
    logic       ten_yuan;
    logic       cancel;
    logic       buy_g1;
    logic       buy_g2;
    logic       on;
    logic       occupy;
    logic       get_good;
    logic       ret_coin;
    logic       good1;
    logic       good2;
    logic [7:0] AN;
    logic [7:0] seg_out;
    logic [3:0] status;

    modport master (
        output one_yuan, ten_yuan, cancel, buy_g1, buy_g2,
        input  on, occupy, get_good, ret_coin, good1, good2, AN, seg_out, status
    );

    modport slave (
        input  one_yuan, ten_yuan, cancel, buy_g1, buy_g2,
        output on, occupy, get_good, ret_coin, good1, good2, AN, seg_out, status
    );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: two-digit multiplexed seven-segment driver. Digit 0 and digit 1
// take turns every SCAN_DIV cycles; digits 2..7 stay blanked.
module seg7_scan
    import vm_pkg::*;
#(
    parameter int unsigned SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    output logic [7:0] an,
    output logic [7:0] seg_out
);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    // Scan divider, digit select and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    // Advance the slot counter and pick the glyph for the active digit.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end
        an_d  = sel_q ? 8'hFD : 8'hFE;
        seg_d = seg7_decode(sel_q ? digit1 : digit0);
    end

    assign an      = an_q;
    assign seg_out = seg_q;
endmodule

// File: rtl/vending_machine.sv
// vending_machine: two-product coin controller with credit balance, timed
// dispense/refund strobes and a balance display.
// Build option: define VM_SEG_DISPLAY_EN to build the seven-segment scan;
// otherwise AN and seg_out are held at 8'hFF.
module vending_machine
    import vm_pkg::*;
#(
    parameter int unsigned PRICE_G1     = DEF_PRICE_G1,
    parameter int unsigned PRICE_G2     = DEF_PRICE_G2,
    parameter int unsigned MAX_BAL      = DEF_MAX_BAL,
    parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV
) (
    input  logic              clk,
    input  logic              rst,
    vending_machine_if.slave  bus
);
    localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [BAL_W-1:0] P1   = BAL_W'(PRICE_G1);
    localparam logic [BAL_W-1:0] P2   = BAL_W'(PRICE_G2);
    localparam logic [BAL_W:0]   MAXB = (BAL_W + 1)'(MAX_BAL);

    state_e           state_q, state_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    logic [PW-1:0]    pulse_q, pulse_d;
    logic [4:0]       hist_q, hist_d;
    logic             on_q, on_d;
    logic             good1_q, good1_d;
    logic             good2_q, good2_d;
    logic             get_good_q, get_good_d;
    logic             ret_coin_q, ret_coin_d;

    logic [4:0]       in_vec, ev;
    logic [BAL_W:0]   coin_sum;
    action_e          act;

    // Input order {buy_g2, buy_g1, cancel, ten_yuan, one_yuan}.
    assign in_vec = {bus.buy_g2, bus.buy_g1, bus.cancel, bus.ten_yuan, bus.one_yuan};
    // Events are masked on the first cycle after reset so inputs already high
    // at release load the history without firing.
    assign ev       = in_vec & ~hist_q & {5{on_q}};
    assign coin_sum = {1'b0, bal_q} + (ev[1] ? (BAL_W + 1)'(10) : (BAL_W + 1)'(1));
    assign hist_d   = in_vec;
    assign on_d     = 1'b1;

    // State and datapath registers, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: every flop uses <= so all registers sample the same pre-edge values.
        if (!rst) begin
            state_q    <= ST_IDLE;
            bal_q      <= '0;
            pulse_q    <= '0;
            hist_q     <= '0;
            on_q       <= 1'b0;
            good1_q    <= 1'b0;
            good2_q    <= 1'b0;
            get_good_q <= 1'b0;
            ret_coin_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bal_q      <= bal_d;
            pulse_q    <= pulse_d;
            hist_q     <= hist_d;
            on_q       <= on_d;
            good1_q    <= good1_d;
            good2_q    <= good2_d;
            get_good_q <= get_good_d;
            ret_coin_q <= ret_coin_d;
        end
    end

    // Pick the single highest-priority event: cancel > buy_g1 > buy_g2 > coin.
    always_comb begin
        act = ACT_NONE;
        if (state_q == ST_IDLE || state_q == ST_CREDIT) begin
            if (ev[2])              act = (bal_q != '0) ? ACT_REFUND : ACT_NONE;
            else if (ev[3])         act = (bal_q >= P1) ? ACT_BUY1 : ACT_NONE;
            else if (ev[4])         act = (bal_q >= P2) ? ACT_BUY2 : ACT_NONE;
            else if (ev[1] | ev[0]) act = (coin_sum > MAXB) ? ACT_REJECT : ACT_COIN;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                case (act)
                    ACT_COIN:           state_d = ST_CREDIT;
                    ACT_BUY1, ACT_BUY2: state_d = ST_VEND;
                    ACT_REFUND:         state_d = ST_REFUND;
                    default:            state_d = state_q;
                endcase
            end
            ST_VEND:   if (pulse_q == '0) state_d = (bal_q != '0) ? ST_CREDIT : ST_IDLE;
            ST_REFUND: if (pulse_q == '0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Balance update and strobe generation; strobes hold through the pulse.
    always_comb begin
        // NOTE: each output gets a default first so no path infers a latch.
        bal_d      = bal_q;
        pulse_d    = pulse_q;
        good1_d    = 1'b0;
        good2_d    = 1'b0;
        get_good_d = 1'b0;
        ret_coin_d = 1'b0;
        case (state_q)
            ST_VEND: begin
                if (pulse_q != '0) begin
                    pulse_d    = pulse_q - 1'b1;
                    good1_d    = good1_q;
                    good2_d    = good2_q;
                    get_good_d = 1'b1;
                end
            end
            ST_REFUND: begin
                if (pulse_q != '0) begin
                    pulse_d    = pulse_q - 1'b1;
                    ret_coin_d = 1'b1;
                end
            end
            default: begin
                case (act)
                    ACT_COIN:   bal_d = coin_sum[BAL_W-1:0];
                    ACT_REJECT: ret_coin_d = 1'b1;
                    ACT_BUY1: begin
                        bal_d      = bal_q - P1;
                        pulse_d    = PW'(PULSE_CYCLES - 1);
                        good1_d    = 1'b1;
                        get_good_d = 1'b1;
                    end
                    ACT_BUY2: begin
                        bal_d      = bal_q - P2;
                        pulse_d    = PW'(PULSE_CYCLES - 1);
                        good2_d    = 1'b1;
                        get_good_d = 1'b1;
                    end
                    ACT_REFUND: begin
                        bal_d      = '0;
                        pulse_d    = PW'(PULSE_CYCLES - 1);
                        ret_coin_d = 1'b1;
                    end
                    default: bal_d = bal_q;
                endcase
            end
        endcase
    end

    assign bus.on       = on_q;
    assign bus.occupy   = (state_q != ST_IDLE);
    assign bus.status   = state_q;
    assign bus.good1    = good1_q;
    assign bus.good2    = good2_q;
    assign bus.get_good = get_good_q;
    assign bus.ret_coin = ret_coin_q;

`ifdef VM_SEG_DISPLAY_EN
    seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk    (clk),
        .rst    (rst),
        .digit0 (4'(bal_q % 7'd10)),
        .digit1 (4'(bal_q / 7'd10)),
        .an     (bus.AN),
        .seg_out(bus.seg_out)
    );
`else
    assign bus.AN      = 8'hFF;
    assign bus.seg_out = 8'hFF;
`endif
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed self-checking bench for vending_machine.
module tb_vending_machine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    vending_machine_if vif ();

    vending_machine dut (
        .clk(clk),
        .rst(rst),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    // Drive one named input (0 one_yuan, 1 ten_yuan, 2 cancel, 3 buy_g1, 4 buy_g2).
    task automatic drive(input int which, input logic v);
        case (which)
            0: vif.one_yuan = v;
            1: vif.ten_yuan = v;
            2: vif.cancel   = v;
            3: vif.buy_g1   = v;
            default: vif.buy_g2 = v;
        endcase
    endtask

    // 2-cycle coin pulse plus 1 low cycle; returns the ret_coin high cycles seen.
    task automatic coin(input int which, output int rets);
        rets = 0;
        drive(which, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(which, 1'b0);
            if (vif.ret_coin) rets++;
        end
    endtask

    // Hold an input for 'hold' cycles and count strobes over an 8-cycle window.
    task automatic press(input int which, input int hold, output int c_g1, output int c_g2,
                         output int c_gg, output int c_ret, output int c_vend, output int c_ref);
        c_g1 = 0; c_g2 = 0; c_gg = 0; c_ret = 0; c_vend = 0; c_ref = 0;
        drive(which, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == hold - 1) drive(which, 1'b0);
            if (vif.good1)    c_g1++;
            if (vif.good2)    c_g2++;
            if (vif.get_good) c_gg++;
            if (vif.ret_coin) c_ret++;
            if (vif.status == 4'b0100) c_vend++;
            if (vif.status == 4'b1000) c_ref++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (vif.on !== 1'b0) begin failures++; $display("FAIL reset_on got %0b want 0", vif.on); end
        checks++; if (vif.status !== 4'b0001) begin failures++; $display("FAIL reset_status got %b want 0001", vif.status); end
        checks++; if ({vif.occupy, vif.get_good, vif.ret_coin, vif.good1, vif.good2} !== 5'b0) begin
            failures++; $display("FAIL reset_strobes got %b want 00000", {vif.occupy, vif.get_good, vif.ret_coin, vif.good1, vif.good2}); end
        checks++; if (vif.AN !== 8'hFF) begin failures++; $display("FAIL reset_an got %h want ff", vif.AN); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (vif.on !== 1'b1) begin failures++; $display("FAIL release_on got %0b want 1", vif.on); end
    endtask

    task automatic test_good1;
        int r, g1, g2, gg, rt, vd, rf;
        for (int i = 0; i < 3; i++) coin(0, r);
        checks++; if (dut.bal_q !== 7'd3) begin failures++; $display("FAIL g1_bal_pre got %0d want 3", dut.bal_q); end
        checks++; if (vif.status !== 4'b0010) begin failures++; $display("FAIL g1_status_pre got %b want 0010", vif.status); end
        press(3, 3, g1, g2, gg, rt, vd, rf);
        checks++; if (g1 !== 4) begin failures++; $display("FAIL g1_good1_cycles got %0d want 4", g1); end
        checks++; if (gg !== 4) begin failures++; $display("FAIL g1_get_good_cycles got %0d want 4", gg); end
        checks++; if (vd !== 4) begin failures++; $display("FAIL g1_vend_cycles got %0d want 4", vd); end
        checks++; if (dut.bal_q !== 7'd0) begin failures++; $display("FAIL g1_bal_post got %0d want 0", dut.bal_q); end
        checks++; if (vif.status !== 4'b0001) begin failures++; $display("FAIL g1_status_post got %b want 0001", vif.status); end
    endtask

    task automatic test_good2_insufficient;
        int r, g1, g2, gg, rt, vd, rf;
        coin(1, r); coin(0, r); coin(0, r);
        checks++; if (dut.bal_q !== 7'd12) begin failures++; $display("FAIL g2_bal_pre got %0d want 12", dut.bal_q); end
        press(4, 1, g1, g2, gg, rt, vd, rf);
        checks++; if (g2 !== 4 || g1 !== 0 || gg !== 4) begin
            failures++; $display("FAIL g2_strobes got g2=%0d g1=%0d gg=%0d want 4 0 4", g2, g1, gg); end
        checks++; if (dut.bal_q !== 7'd2) begin failures++; $display("FAIL g2_bal_post got %0d want 2", dut.bal_q); end
        checks++; if (vif.status !== 4'b0010) begin failures++; $display("FAIL g2_status_post got %b want 0010", vif.status); end
        press(3, 1, g1, g2, gg, rt, vd, rf);
        checks++; if (g1 !== 0 || gg !== 0 || vd !== 0) begin
            failures++; $display("FAIL insuff_ignored got g1=%0d gg=%0d vend=%0d want 0 0 0", g1, gg, vd); end
        checks++; if (dut.bal_q !== 7'd2) begin failures++; $display("FAIL insuff_bal got %0d want 2", dut.bal_q); end
    endtask

    task automatic test_cancel;
        int g1, g2, gg, rt, vd, rf;
        press(2, 1, g1, g2, gg, rt, vd, rf);
        checks++; if (rt !== 4 || rf !== 4) begin
            failures++; $display("FAIL cancel_ret got ret=%0d refund=%0d want 4 4", rt, rf); end
        checks++; if (dut.bal_q !== 7'd0) begin failures++; $display("FAIL cancel_bal got %0d want 0", dut.bal_q); end
        checks++; if (vif.status !== 4'b0001) begin failures++; $display("FAIL cancel_status got %b want 0001", vif.status); end
        press(2, 1, g1, g2, gg, rt, vd, rf);
        checks++; if (rt !== 0 || rf !== 0 || vif.status !== 4'b0001) begin
            failures++; $display("FAIL cancel_idle got ret=%0d refund=%0d status=%b want 0 0 0001", rt, rf, vif.status); end
    endtask

    task automatic test_saturation;
        int r, sum, g1, g2, gg, rt, vd, rf;
        for (int i = 0; i < 10; i++) begin
            coin(1, r);
            checks++; if (r !== ((i == 9) ? 1 : 0)) begin
                failures++; $display("FAIL sat_ten_reject coin=%0d got %0d want %0d", i, r, (i == 9) ? 1 : 0); end
        end
        checks++; if (dut.bal_q !== 7'd90) begin failures++; $display("FAIL sat_bal90 got %0d want 90", dut.bal_q); end
        sum = 0;
        for (int i = 0; i < 9; i++) begin coin(0, r); sum += r; end
        checks++; if (sum !== 0 || dut.bal_q !== 7'd99) begin
            failures++; $display("FAIL sat_bal99 got bal=%0d rets=%0d want 99 0", dut.bal_q, sum); end
        coin(0, r);
        checks++; if (r !== 1 || dut.bal_q !== 7'd99) begin
            failures++; $display("FAIL sat_one_reject got bal=%0d rets=%0d want 99 1", dut.bal_q, r); end
        press(2, 1, g1, g2, gg, rt, vd, rf);
        checks++; if (rt !== 4 || dut.bal_q !== 7'd0) begin
            failures++; $display("FAIL sat_refund got ret=%0d bal=%0d want 4 0", rt, dut.bal_q); end
    endtask

    task automatic test_reset_mid;
        int r;
        for (int i = 0; i < 4; i++) coin(0, r);
        vif.buy_g1 = 1'b1;
        @(negedge clk);
        vif.buy_g1 = 1'b0;
        checks++; if (vif.status !== 4'b0100 || dut.bal_q !== 7'd1) begin
            failures++; $display("FAIL mid_vend got status=%b bal=%0d want 0100 1", vif.status, dut.bal_q); end
        vif.one_yuan = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({vif.on, vif.occupy, vif.get_good, vif.ret_coin, vif.good1, vif.good2} !== 6'b0
                      || vif.status !== 4'b0001 || dut.bal_q !== 7'd0) begin
            failures++; $display("FAIL mid_reset got outs=%b status=%b bal=%0d want 000000 0001 0",
                {vif.on, vif.occupy, vif.get_good, vif.ret_coin, vif.good1, vif.good2}, vif.status, dut.bal_q); end
        checks++; if (vif.AN !== 8'hFF || vif.seg_out !== 8'hFF) begin
            failures++; $display("FAIL mid_reset_disp got an=%h seg=%h want ff ff", vif.AN, vif.seg_out); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dut.bal_q !== 7'd0 || vif.status !== 4'b0001 || vif.on !== 1'b1) begin
            failures++; $display("FAIL held_input_no_event got bal=%0d status=%b on=%0b want 0 0001 1",
                dut.bal_q, vif.status, vif.on); end
        vif.one_yuan = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_display;
        int r, g1, g2, gg, rt, vd, rf, seen_fe, seen_fd;
        coin(1, r); coin(0, r); coin(0, r);
        seen_fe = 0; seen_fd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
`ifdef VM_SEG_DISPLAY_EN
            if (vif.AN == 8'hFE) begin
                seen_fe++;
                checks++; if (vif.seg_out !== 8'hA4) begin failures++; $display("FAIL disp_units got %h want a4", vif.seg_out); end
            end else if (vif.AN == 8'hFD) begin
                seen_fd++;
                checks++; if (vif.seg_out !== 8'hF9) begin failures++; $display("FAIL disp_tens got %h want f9", vif.seg_out); end
            end else begin
                checks++; failures++; $display("FAIL disp_an got %h want fe or fd", vif.AN);
            end
`else
            checks++; if (vif.AN !== 8'hFF || vif.seg_out !== 8'hFF) begin
                failures++; $display("FAIL disp_off got an=%h seg=%h want ff ff", vif.AN, vif.seg_out); end
`endif
        end
`ifdef VM_SEG_DISPLAY_EN
        checks++; if (seen_fe < 16 || seen_fd < 16) begin
            failures++; $display("FAIL disp_alternate got fe=%0d fd=%0d want >=16 each", seen_fe, seen_fd); end
`endif
        press(2, 1, g1, g2, gg, rt, vd, rf);
        checks++; if (dut.bal_q !== 7'd0) begin failures++; $display("FAIL disp_clear got %0d want 0", dut.bal_q); end
    endtask

    initial begin
        vif.one_yuan = 1'b0;
        vif.ten_yuan = 1'b0;
        vif.cancel   = 1'b0;
        vif.buy_g1   = 1'b0;
        vif.buy_g2   = 1'b0;
        test_reset();
        test_good1();
        test_good2_insufficient();
        test_cancel();
        test_saturation();
        test_reset_mid();
        test_display();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
